// File: rtl/dds_phase_mac.sv
// -----------------------------------------------------------------------------
// dds_phase_mac
//
// Pipelined phase multiply-accumulate for the DDS path of the DAC controller.
// For every valid sample it computes
//   full = (timestamp - time_offset) * freq
//          + (phase_offset << (PHASE_WIDTH - OFFSET_WIDTH))
//          + E                                 (all mod 2^PHASE_WIDTH)
// where E is either the external accu_phase or the internally held
// last_phase (phase continuity across segments).
//
// Pipeline (fixed latency 4, one sample per cycle, no backpressure):
//   s0  capture: diff, freq, aligned offset, accumulator source
//   s1  17x17 partial products (tiles that only feed bits >= PHASE_WIDTH
//       are pruned)
//   s2  carry-save reduction of partial products, offset and E
//   s3  final carry-propagate add -> full
//   out phase_out / last_phase register, out_valid pulse
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   clear             synchronous flush of the pipeline and last_phase
//   in_valid          sample strobe
//   timestamp         current time            [TIME_WIDTH]
//   time_offset       segment start time      [TIME_WIDTH]
//   freq              frequency tuning word   [FREQ_WIDTH]
//   phase_offset      static phase offset     [OFFSET_WIDTH]
//   accu_phase        external accumulated phase [PHASE_WIDTH]
//   accu_src          0: use accu_phase, 1: use last_phase
//   out_valid         result strobe
//   phase_out         top OUT_WIDTH bits of full
//   last_phase        full-precision phase of the most recent result
//
// Optional feature: define DDS_PHASE_MAC_ROUND_EN to round phase_out
// half-up to OUT_WIDTH bits (last_phase stays unrounded). Undefined gives
// plain truncation.
// -----------------------------------------------------------------------------
module dds_phase_mac #(
  parameter int TIME_WIDTH   = 48,
  parameter int FREQ_WIDTH   = 48,
  parameter int PHASE_WIDTH  = 48,
  parameter int OFFSET_WIDTH = 14,
  parameter int OUT_WIDTH    = 48
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic [TIME_WIDTH-1:0]   timestamp,
  input  logic [TIME_WIDTH-1:0]   time_offset,
  input  logic [FREQ_WIDTH-1:0]   freq,
  input  logic [OFFSET_WIDTH-1:0] phase_offset,
  input  logic [PHASE_WIDTH-1:0]  accu_phase,
  input  logic                    accu_src,
  output logic                    out_valid,
  output logic [OUT_WIDTH-1:0]    phase_out,
  output logic [PHASE_WIDTH-1:0]  last_phase
);

  localparam int TILE    = 17;
  localparam int PP_W    = 2 * TILE;
  localparam int N_T     = (TIME_WIDTH + TILE - 1) / TILE;
  localparam int N_F     = (FREQ_WIDTH + TILE - 1) / TILE;
  localparam int T_EXT_W = N_T * TILE;
  localparam int F_EXT_W = N_F * TILE;
  localparam int OFF_SH  = PHASE_WIDTH - OFFSET_WIDTH;
  localparam int OUT_SH  = PHASE_WIDTH - OUT_WIDTH;

  // ---------------------------------------------------------------------------
  // Control / output state (reset and cleared)
  // ---------------------------------------------------------------------------
  logic                   s0_valid_d, s0_valid_q;
  logic                   s1_valid_d, s1_valid_q;
  logic                   s2_valid_d, s2_valid_q;
  logic                   s3_valid_d, s3_valid_q;
  logic                   out_valid_d, out_valid_q;
  logic [OUT_WIDTH-1:0]   phase_out_d, phase_out_q;
  logic [PHASE_WIDTH-1:0] last_phase_d, last_phase_q;

  // ---------------------------------------------------------------------------
  // Datapath state (free-running, qualified by the stage valids)
  // ---------------------------------------------------------------------------
  logic [TIME_WIDTH-1:0]  s0_diff_d, s0_diff_q;
  logic [FREQ_WIDTH-1:0]  s0_freq_d, s0_freq_q;
  logic [PHASE_WIDTH-1:0] s0_off_d, s0_off_q;
  logic [PHASE_WIDTH-1:0] s0_e_d, s0_e_q;

  logic [PP_W-1:0]        s1_pp_d [N_T][N_F];
  logic [PP_W-1:0]        s1_pp_q [N_T][N_F];
  logic [PHASE_WIDTH-1:0] s1_off_d, s1_off_q;
  logic [PHASE_WIDTH-1:0] s1_e_d, s1_e_q;

  logic [PHASE_WIDTH-1:0] s2_sum_d, s2_sum_q;
  logic [PHASE_WIDTH-1:0] s2_carry_d, s2_carry_q;

  logic [PHASE_WIDTH-1:0] s3_full_d, s3_full_q;

  // Combinational helpers
  logic [T_EXT_W-1:0]     diff_ext;
  logic [F_EXT_W-1:0]     freq_ext;
  logic [PHASE_WIDTH-1:0] csa_sum, csa_carry, csa_term, csa_next;
  logic [PHASE_WIDTH-1:0] round_src;

  // ---------------------------------------------------------------------------
  // Stage 0: capture. E is taken from last_phase as it stands now; samples
  // still in flight have not updated it yet (intended continuity behaviour).
  // ---------------------------------------------------------------------------
  always_comb begin
    s0_valid_d = in_valid;
    s0_diff_d  = timestamp - time_offset;
    s0_freq_d  = freq;
    s0_off_d   = PHASE_WIDTH'(phase_offset) << OFF_SH;
    s0_e_d     = accu_src ? last_phase_q : accu_phase;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: DSP-sized partial products. A tile whose weight 2^(17*(i+j))
  // is already at or above 2^PHASE_WIDTH cannot affect the result.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a value before any branch so no
    // latch can be inferred.
    diff_ext   = T_EXT_W'(s0_diff_q);
    freq_ext   = F_EXT_W'(s0_freq_q);
    s1_valid_d = s0_valid_q;
    s1_off_d   = s0_off_q;
    s1_e_d     = s0_e_q;
    for (int i = 0; i < N_T; i++) begin
      for (int j = 0; j < N_F; j++) begin
        s1_pp_d[i][j] = '0;
        if (TILE * (i + j) < PHASE_WIDTH) begin
          s1_pp_d[i][j] = PP_W'(diff_ext[i*TILE +: TILE]) *
                          PP_W'(freq_ext[j*TILE +: TILE]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: 3:2 carry-save chain over offset, E and the shifted partial
  // products. Carries out of bit PHASE_WIDTH-1 are dropped (mod arithmetic).
  // ---------------------------------------------------------------------------
  always_comb begin
    s2_valid_d = s1_valid_q;
    csa_sum    = s1_off_q;
    csa_carry  = s1_e_q;
    csa_term   = '0;
    csa_next   = '0;
    for (int i = 0; i < N_T; i++) begin
      for (int j = 0; j < N_F; j++) begin
        if (TILE * (i + j) < PHASE_WIDTH) begin
          csa_term  = PHASE_WIDTH'(s1_pp_q[i][j]) << (TILE * (i + j));
          csa_next  = csa_sum ^ csa_carry ^ csa_term;
          csa_carry = ((csa_sum & csa_carry) | (csa_sum & csa_term) |
                       (csa_carry & csa_term)) << 1;
          csa_sum   = csa_next;
        end
      end
    end
    s2_sum_d   = csa_sum;
    s2_carry_d = csa_carry;
  end

  // ---------------------------------------------------------------------------
  // Stage 3: resolve carry-save pair into the full-precision phase.
  // ---------------------------------------------------------------------------
  always_comb begin
    s3_valid_d = s2_valid_q;
    s3_full_d  = s2_sum_q + s2_carry_q;
  end

  // ---------------------------------------------------------------------------
  // Output stage: optional half-up rounding affects phase_out only.
  // ---------------------------------------------------------------------------
`ifdef DDS_PHASE_MAC_ROUND_EN
  localparam int RND_SH = (OUT_WIDTH < PHASE_WIDTH) ? PHASE_WIDTH - OUT_WIDTH - 1 : 0;
  localparam logic [PHASE_WIDTH-1:0] RND_ADD =
    (OUT_WIDTH < PHASE_WIDTH) ? (PHASE_WIDTH'(1) << RND_SH) : {PHASE_WIDTH{1'b0}};
  assign round_src = s3_full_q + RND_ADD;
`else
  assign round_src = s3_full_q;
`endif

  always_comb begin
    out_valid_d  = s3_valid_q;
    phase_out_d  = phase_out_q;
    last_phase_d = last_phase_q;
    if (s3_valid_q) begin
      phase_out_d  = OUT_WIDTH'(round_src >> OUT_SH);
      last_phase_d = s3_full_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      s0_valid_q   <= 1'b0;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s3_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      phase_out_q  <= '0;
      last_phase_q <= '0;
    end else begin
      s0_valid_q   <= s0_valid_d;
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      s3_valid_q   <= s3_valid_d;
      out_valid_q  <= out_valid_d;
      phase_out_q  <= phase_out_d;
      last_phase_q <= last_phase_d;
    end
  end

  // NOTE: datapath registers carry no reset; the stage valids alone decide
  // whether their contents ever reach the outputs.
  always_ff @(posedge clk) begin
    s0_diff_q  <= s0_diff_d;
    s0_freq_q  <= s0_freq_d;
    s0_off_q   <= s0_off_d;
    s0_e_q     <= s0_e_d;
    s1_pp_q    <= s1_pp_d;
    s1_off_q   <= s1_off_d;
    s1_e_q     <= s1_e_d;
    s2_sum_q   <= s2_sum_d;
    s2_carry_q <= s2_carry_d;
    s3_full_q  <= s3_full_d;
  end

  assign out_valid  = out_valid_q;
  assign phase_out  = phase_out_q;
  assign last_phase = last_phase_q;

endmodule

// File: tb/tb_dds_phase_mac.sv
// -----------------------------------------------------------------------------
// tb_dds_phase_mac
//
// Self-checking bench for dds_phase_mac. Two instances share the stimulus:
// the default-width one and one with OUT_WIDTH = 16 for the truncation /
// rounding cases. A queue-based reference model computes each sample's phase
// with plain wide arithmetic and releases it four edges after capture.
// -----------------------------------------------------------------------------
module tb_dds_phase_mac;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, accu_src;
  logic [47:0] timestamp, time_offset, freq, accu_phase;
  logic [13:0] phase_offset;

  logic        out_valid, out_valid16;
  logic [47:0] phase_out, last_phase, last_phase16;
  logic [15:0] phase_out16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dds_phase_mac dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .in_valid     (in_valid),
    .timestamp    (timestamp),
    .time_offset  (time_offset),
    .freq         (freq),
    .phase_offset (phase_offset),
    .accu_phase   (accu_phase),
    .accu_src     (accu_src),
    .out_valid    (out_valid),
    .phase_out    (phase_out),
    .last_phase   (last_phase)
  );

  dds_phase_mac #(.OUT_WIDTH(16)) dut16 (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .in_valid     (in_valid),
    .timestamp    (timestamp),
    .time_offset  (time_offset),
    .freq         (freq),
    .phase_offset (phase_offset),
    .accu_phase   (accu_phase),
    .accu_src     (accu_src),
    .out_valid    (out_valid16),
    .phase_out    (phase_out16),
    .last_phase   (last_phase16)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [47:0] ref_full(input logic [47:0] ts, input logic [47:0] to,
                                           input logic [47:0] fr, input logic [13:0] po,
                                           input logic [47:0] e);
    logic [47:0] diff;
    logic [95:0] prod;
    logic [47:0] off;
    diff = ts - to;
    prod = {48'd0, diff} * {48'd0, fr};
    off  = {po, 34'd0};
    return prod[47:0] + off + e;
  endfunction

  function automatic logic [15:0] ref_out16(input logic [47:0] full);
    logic [47:0] r;
`ifdef DDS_PHASE_MAC_ROUND_EN
    r = full + 48'h0000_8000_0000;
`else
    r = full;
`endif
    return r[47:32];
  endfunction

  typedef struct {
    int          due;
    logic [47:0] full;
  } pend_t;

  pend_t       pend_q[$];
  pend_t       m_pop;
  int          cyc = 0;
  logic        exp_valid = 1'b0;
  logic [47:0] exp_phase = '0;
  logic [47:0] exp_last  = '0;
  logic [15:0] exp_p16   = '0;
  logic [47:0] m_e;

  always @(posedge clk) begin
    cyc++;
    exp_valid = 1'b0;
    if (reset || clear) begin
      pend_q.delete();
      exp_phase = '0;
      exp_last  = '0;
      exp_p16   = '0;
    end else begin
      // Capture sees last_phase from before this edge's output update.
      if (in_valid) begin
        m_e = accu_src ? exp_last : accu_phase;
        pend_q.push_back('{cyc + 4,
                           ref_full(timestamp, time_offset, freq, phase_offset, m_e)});
      end
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        m_pop     = pend_q.pop_front();
        exp_valid = 1'b1;
        exp_phase = m_pop.full;
        exp_last  = m_pop.full;
        exp_p16   = ref_out16(m_pop.full);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers (stimulus only)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[47:0];
  endfunction

  task automatic idle_inputs();
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; accu_src = 1'b0;
    timestamp = '0; time_offset = '0; freq = '0; accu_phase = '0; phase_offset = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; in_valid = 1'b1;
    timestamp = rnd48(); freq = rnd48(); accu_phase = rnd48();
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (phase_out !== 48'h0) begin errors++; $display("FAIL reset_phase_out: got %h want 0", phase_out); end
    checks++; if (last_phase !== 48'h0) begin errors++; $display("FAIL reset_last_phase: got %h want 0", last_phase); end
    checks++; if (phase_out16 !== 16'h0) begin errors++; $display("FAIL reset_phase_out16: got %h want 0", phase_out16); end
    reset = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_ghost k=%0d: got %b want 0", k, out_valid); end
    end
  endtask

  task automatic test_basic();
    idle_inputs();
    timestamp = 48'd1000; time_offset = 48'd400; freq = 48'h10;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++; if (out_valid !== (k == 4)) begin errors++; $display("FAIL basic_latency t+%0d: got %b want %b", k, out_valid, (k == 4)); end
      if (k == 4 || k == 6) begin
        checks++; if (phase_out !== 48'h2580) begin errors++; $display("FAIL basic_phase t+%0d: got %h want 2580", k, phase_out); end
      end
    end
    checks++; if (last_phase !== 48'h2580) begin errors++; $display("FAIL basic_last: got %h want 2580", last_phase); end
  endtask

  task automatic test_offset_wrap();
    idle_inputs();
    phase_offset = 14'd1; timestamp = 48'd77; time_offset = 48'd77; freq = rnd48();
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (4) tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL offset_valid: got %b want 1", out_valid); end
    checks++; if (phase_out !== 48'h0004_0000_0000) begin errors++; $display("FAIL offset_align: got %h want 000400000000", phase_out); end
    idle_inputs();
    timestamp = 48'd0; time_offset = 48'd1; freq = 48'd1; accu_phase = 48'd1;
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (4) tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b want 1", out_valid); end
    checks++; if (phase_out !== 48'h0) begin errors++; $display("FAIL wrap_phase: got %h want 0", phase_out); end
  endtask

  task automatic test_back_to_back();
    int seen;
    idle_inputs();
    freq = 48'd1; time_offset = 48'd0;
    seen = 0;
    for (int n = 0; n < 14; n++) begin
      if (n < 8) begin in_valid = 1'b1; timestamp = 48'(n + 1); end
      else in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== (n >= 4 && n < 12)) begin errors++; $display("FAIL b2b_valid n=%0d: got %b want %b", n, out_valid, (n >= 4 && n < 12)); end
      if (out_valid === 1'b1) begin
        seen++;
        checks++; if (phase_out !== 48'(n - 3)) begin errors++; $display("FAIL b2b_phase n=%0d: got %h want %h", n, phase_out, 48'(n - 3)); end
      end
    end
    checks++; if (seen != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", seen); end
  endtask

  task automatic test_continuity();
    idle_inputs();
    clear = 1'b1; tick(); clear = 1'b0;
    accu_src = 1'b1; accu_phase = rnd48() | 48'h1;
    timestamp = 48'h100; time_offset = 48'd0; freq = 48'd1;
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (4) tick();
    checks++; if (out_valid !== 1'b1 || phase_out !== 48'h100) begin errors++; $display("FAIL cont_first: got v=%b %h want v=1 100", out_valid, phase_out); end
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (4) tick();
    checks++; if (out_valid !== 1'b1 || phase_out !== 48'h200) begin errors++; $display("FAIL cont_second: got v=%b %h want v=1 200", out_valid, phase_out); end
    checks++; if (last_phase !== 48'h200) begin errors++; $display("FAIL cont_last: got %h want 200", last_phase); end
    clear = 1'b1; tick(); clear = 1'b0;
    in_valid = 1'b1; tick(); tick(); in_valid = 1'b0;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b1 || phase_out !== 48'h100) begin errors++; $display("FAIL cont_b2b_first: got v=%b %h want v=1 100", out_valid, phase_out); end
    tick();
    checks++; if (out_valid !== 1'b1 || phase_out !== 48'h100) begin errors++; $display("FAIL cont_b2b_second: got v=%b %h want v=1 100", out_valid, phase_out); end
    checks++; if (last_phase !== 48'h100) begin errors++; $display("FAIL cont_b2b_last: got %h want 100", last_phase); end
    accu_src = 1'b0;
  endtask

  task automatic test_flush(input bit use_reset);
    string nm;
    nm = use_reset ? "reset_mid" : "clear_mid";
    idle_inputs();
    timestamp = 48'h1234; freq = 48'd1;
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (4) tick();
    checks++; if (phase_out !== 48'h1234) begin errors++; $display("FAIL %s_prefill: got %h want 1234", nm, phase_out); end
    timestamp = 48'h5555; freq = 48'd3;
    in_valid = 1'b1;
    tick(); tick();
    if (use_reset) reset = 1'b1; else clear = 1'b1;
    tick();
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_no_valid k=%0d: got %b want 0", nm, k, out_valid); end
    end
    checks++; if (last_phase !== 48'h0) begin errors++; $display("FAIL %s_last: got %h want 0", nm, last_phase); end
    checks++; if (phase_out !== 48'h0) begin errors++; $display("FAIL %s_phase: got %h want 0", nm, phase_out); end
  endtask

  task automatic test_out16();
    logic [15:0] want_a, want_b;
`ifdef DDS_PHASE_MAC_ROUND_EN
    want_a = 16'h0001; want_b = 16'h0000;
`else
    want_a = 16'h0000; want_b = 16'hFFFF;
`endif
    idle_inputs();
    timestamp = 48'h0000_8000_0000; freq = 48'd1;
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (4) tick();
    checks++; if (out_valid16 !== 1'b1 || phase_out16 !== want_a) begin errors++; $display("FAIL out16_half: got v=%b %h want v=1 %h", out_valid16, phase_out16, want_a); end
    checks++; if (last_phase16 !== 48'h0000_8000_0000) begin errors++; $display("FAIL out16_last_unrounded: got %h want 000080000000", last_phase16); end
    checks++; if (phase_out !== 48'h0000_8000_0000) begin errors++; $display("FAIL out48_noop: got %h want 000080000000", phase_out); end
    idle_inputs();
    accu_phase = 48'hFFFF_8000_0000;
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (4) tick();
    checks++; if (out_valid16 !== 1'b1 || phase_out16 !== want_b) begin errors++; $display("FAIL out16_top: got v=%b %h want v=1 %h", out_valid16, phase_out16, want_b); end
  endtask

  task automatic test_random();
    int r;
    idle_inputs();
    for (int n = 0; n < 500; n++) begin
      r            = int'($urandom_range(0, 99));
      reset        = (r == 0);
      clear        = (r == 1 || r == 2);
      in_valid     = ($urandom_range(0, 99) < 70);
      accu_src     = ($urandom_range(0, 2) == 0);
      timestamp    = rnd48();
      time_offset  = ($urandom_range(0, 1) == 1) ? rnd48() : timestamp - 48'($urandom_range(0, 4095));
      freq         = ($urandom_range(0, 3) == 0) ? 48'($urandom_range(0, 255)) : rnd48();
      phase_offset = 14'($urandom);
      accu_phase   = rnd48();
      tick();
      checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL rand_valid n=%0d: got %b want %b", n, out_valid, exp_valid); end
      checks++; if (phase_out !== exp_phase) begin errors++; $display("FAIL rand_phase n=%0d: got %h want %h", n, phase_out, exp_phase); end
      checks++; if (last_phase !== exp_last) begin errors++; $display("FAIL rand_last n=%0d: got %h want %h", n, last_phase, exp_last); end
      checks++; if (out_valid16 !== exp_valid) begin errors++; $display("FAIL rand_valid16 n=%0d: got %b want %b", n, out_valid16, exp_valid); end
      checks++; if (phase_out16 !== exp_p16) begin errors++; $display("FAIL rand_phase16 n=%0d: got %h want %h", n, phase_out16, exp_p16); end
      checks++; if (last_phase16 !== exp_last) begin errors++; $display("FAIL rand_last16 n=%0d: got %h want %h", n, last_phase16, exp_last); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_basic();
    test_offset_wrap();
    test_back_to_back();
    test_continuity();
    test_flush(1'b0);
    test_flush(1'b1);
    test_out16();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_phase_mac.md
Name: dds_phase_mac

Overview:
- Pipelined phase MAC for the DAC controller DDS path. Per valid sample it computes phase = (timestamp - time_offset) * freq + phase_offset aligned to the MSBs + accumulated phase, modulo 2^PHASE_WIDTH.
- Parametrised successor of the fixed 48-bit MAC: configurable widths, valid-tagged fixed-latency pipeline, synchronous clear, and an internal phase-continuity source.
- Sits between the RTO timestamp/parameter registers and the DDS phase-to-amplitude stage.

Parameters:
- TIME_WIDTH, 48, width of timestamp and time_offset (unsigned).
- FREQ_WIDTH, 48, width of the frequency tuning word (unsigned).
- PHASE_WIDTH, 48, internal phase width and accu_phase width; must be <= TIME_WIDTH + FREQ_WIDTH.
- OFFSET_WIDTH, 14, width of phase_offset; must be <= PHASE_WIDTH.
- OUT_WIDTH, 48, width of phase_out; must be <= PHASE_WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous pipeline flush and last_phase clear
- in_valid  in  1  sample strobe; no backpressure, accepted every cycle it is high
- timestamp  in  TIME_WIDTH  current time
- time_offset  in  TIME_WIDTH  segment start time
- freq  in  FREQ_WIDTH  frequency tuning word
- phase_offset  in  OFFSET_WIDTH  static phase offset
- accu_phase  in  PHASE_WIDTH  external accumulated phase
- accu_src  in  1  0 selects accu_phase; 1 selects internal last_phase
- out_valid  out  1  result strobe
- phase_out  out  OUT_WIDTH  result, top OUT_WIDTH bits of the full phase
- last_phase  out  PHASE_WIDTH  full-precision phase of the most recent output

Behaviour:
- Reset (clk edge with reset=1): out_valid=0, phase_out=0, last_phase=0, all stage valids 0. Reset takes priority over clear and in_valid.
- clear=1 without reset: same effect as reset. An in_valid sample in the same cycle is dropped.
- Latency is fixed at 4 cycles: in_valid high at edge t gives out_valid high at edge t+4. Throughput is one sample per cycle. out_valid is a one-cycle pulse per sample.
- Stage 0 (capture):
  - diff = (timestamp - time_offset) mod 2^TIME_WIDTH.
  - E = accu_src ? last_phase : accu_phase, sampled in the in_valid cycle.
  - off = phase_offset << (PHASE_WIDTH - OFFSET_WIDTH).
- Stages 1-2: partial products of diff x freq with DSP-sized tiles, at most 17x17 unsigned each, and a carry-save sum. Only bits [PHASE_WIDTH-1:0] of the product are retained; higher partial products may be pruned.
- Stage 3: full = (prod + off + E) mod 2^PHASE_WIDTH. All arithmetic is unsigned and wraps silently; no saturation.
- Output:
  - phase_out = full[PHASE_WIDTH-1 -: OUT_WIDTH] (see optional feature for rounding).
  - last_phase <= full on each out_valid.
- phase_out and last_phase hold their values while out_valid=0.
- Continuity hazard: with accu_src=1, E takes last_phase as it stands in the capture cycle. Samples still in flight do not update it until they exit. This is required behaviour, not a bug.
- in_valid low: stage valids shift in 0 and data registers may toggle freely. Only valid-tagged data reaches the outputs.

Optional Feature:
- Macro DDS_PHASE_MAC_ROUND_EN.
- Defined: phase_out is rounded half-up to OUT_WIDTH bits. Add 1 << (PHASE_WIDTH - OUT_WIDTH - 1) to full before truncation, wrapping mod 2^PHASE_WIDTH. last_phase stays unrounded. No-op when OUT_WIDTH == PHASE_WIDTH. Latency is unchanged (4).
- Undefined: plain truncation.

Test Plan:
- Basic product, defaults: timestamp=1000, time_offset=400, freq=0x10, phase_offset=0, accu_phase=0, accu_src=0, in_valid pulse at t -> out_valid at t+4 only, phase_out=0x2580.
- Offset alignment and wrap: phase_offset=1, diff=0 -> phase_out=0x0004_0000_0000. Then timestamp=0, time_offset=1, freq=1, accu_phase=1, phase_offset=0 -> phase_out=0.
- Back-to-back stream: 8 consecutive valid samples with freq=1, timestamp=k, time_offset=0 -> 8 consecutive out_valid cycles, phase_out=k in order, no gaps.
- Continuity: accu_src=1, single sample with prod=0x100, then idle 4 cycles, then second sample with prod=0x100 -> outputs 0x100 then 0x200. Same pair issued back-to-back -> 0x100, 0x100.
- Clear/reset mid-flight: 3 samples issued, clear=1 at the 2nd cycle after the first issue -> no out_valid ever appears for those samples; last_phase=0. Repeat with reset=1 -> identical behaviour, and phase_out=0.
- OUT_WIDTH=16, with and without DDS_PHASE_MAC_ROUND_EN: full=0x0000_8000_0000 -> 0x0001 rounded, 0x0000 truncated. full=0xFFFF_8000_0000 -> 0x0000 rounded, 0xFFFF truncated.
